// File: rtl/lock_range_sweep.sv
// Lock-range sweep controller.
//
// Steps a reference phase-accumulator value k from k_start to k_stop in
// increments of k_step. At each k it waits SETTLE_CYCLES for the loop
// under test to settle, then watches the phase-detector error for up to
// WINDOW_CYCLES. A run of LOCK_CYCLES consecutive in-tolerance samples
// declares lock at that k. The lowest and highest locked k are reported.
//
// Ports:
//   fpga_clk_i           single clock for all logic
//   rst_pbn_i            asynchronous active-low reset
//   start_i              level-sampled sweep request (ignored while busy)
//   abort_i              abandon current sweep, return to IDLE
//   k_start_i/k_stop_i/k_step_i  unsigned sweep bounds and increment
//   error_i              signed 8-bit phase error from the loop under test
//   k_val_o              k driven to the reference accumulator
//   busy_o/done_o/found_o status flags
//   lock_lo_o/lock_hi_o  lowest / highest locked k
module lock_range_sweep #(
    parameter int ACCUM_WIDTH   = 12,
    parameter int SETTLE_CYCLES = 4096,
    parameter int WINDOW_CYCLES = 8192,
    parameter int LOCK_CYCLES   = 1024,
    parameter int ERR_TOL       = 8
) (
    input  logic                   fpga_clk_i,
    input  logic                   rst_pbn_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [ACCUM_WIDTH-1:0] k_start_i,
    input  logic [ACCUM_WIDTH-1:0] k_stop_i,
    input  logic [ACCUM_WIDTH-1:0] k_step_i,
    input  logic signed [7:0]      error_i,
    output logic [ACCUM_WIDTH-1:0] k_val_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   found_o,
    output logic [ACCUM_WIDTH-1:0] lock_lo_o,
    output logic [ACCUM_WIDTH-1:0] lock_hi_o
);

    localparam int AW      = ACCUM_WIDTH;
    localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RUN_W   = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [RUN_W-1:0] LOCK_RUN    = RUN_W'(LOCK_CYCLES);
    localparam logic [7:0]       TOL8        = 8'(ERR_TOL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        STEP    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   stop_q, stop_d;
    logic [AW-1:0]   step_q, step_d;
    logic [AW-1:0]   lo_q, lo_d;
    logic [AW-1:0]   hi_q, hi_d;
    logic            found_q, found_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic [7:0]      err_mag;
    logic            in_tol;
    logic [RUN_W-1:0] run_inc;
    logic [AW:0]     k_next;

    // |error| in 8 bits; -128 has no positive counterpart so it clamps to 127.
    always_comb begin
        if (error_i == 8'sh80)
            err_mag = 8'd127;
        else if (error_i[7])
            err_mag = 8'(~error_i + 8'sd1);
        else
            err_mag = 8'(error_i);
    end

    assign in_tol  = (err_mag <= TOL8);
    assign run_inc = run_q + RUN_W'(1);
    // Extra bit catches a carry out of the accumulator width.
    assign k_next  = {1'b0, k_q} + {1'b0, step_q};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stop_d  = stop_q;
        step_d  = step_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        found_d = found_q;
        cnt_d   = cnt_q;
        run_d   = run_q;

        if (abort_i) begin
            // k and results are kept so software can see where the sweep stopped.
            state_d = IDLE;
            cnt_d   = '0;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        k_d     = k_start_i;
                        stop_d  = k_stop_i;
                        step_d  = (k_step_i == '0) ? AW'(1) : k_step_i;
                        found_d = 1'b0;
                        lo_d    = '0;
                        hi_d    = '0;
                        cnt_d   = '0;
                        run_d   = '0;
                        state_d = (k_start_i > k_stop_i) ? DONE : SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        run_d   = '0;
                        state_d = MEASURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (in_tol && (run_inc == LOCK_RUN)) begin
                        // Lock wins even on the last window cycle.
                        found_d = 1'b1;
                        hi_d    = k_q;
                        if (!found_q)
                            lo_d = k_q;
                        state_d = STEP;
                    end else begin
                        run_d = in_tol ? run_inc : '0;
                        if (cnt_q == WINDOW_LAST)
                            state_d = STEP;
                        else
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STEP: begin
                    cnt_d = '0;
                    run_d = '0;
                    if (k_next[AW] || (k_next[AW-1:0] > stop_q)) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_next[AW-1:0];
                        state_d = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Status flags are registered copies of the next state.
        busy_d = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == STEP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            found_q <= found_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    assign k_val_o   = k_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign found_o   = found_q;
    assign lock_lo_o = lo_q;
    assign lock_hi_o = hi_q;

endmodule

// File: tb/tb_lock_range_sweep.sv
// Directed bench for lock_range_sweep with short settle/window/lock times.
module tb_lock_range_sweep;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] k_start = '0, k_stop = '0, k_step = '0;
    logic signed [7:0] err = '0;
    logic [AW-1:0] k_val, lo, hi;
    logic          busy, done, found;

    int mode = 0;
    int ph   = 0;
    int n_pass = 0;
    int n_total = 0;

    lock_range_sweep #(
        .ACCUM_WIDTH(AW), .SETTLE_CYCLES(4), .WINDOW_CYCLES(16),
        .LOCK_CYCLES(4), .ERR_TOL(8)
    ) dut (
        .fpga_clk_i(clk), .rst_pbn_i(rst_n), .start_i(start), .abort_i(abort),
        .k_start_i(k_start), .k_stop_i(k_stop), .k_step_i(k_step), .error_i(err),
        .k_val_o(k_val), .busy_o(busy), .done_o(done), .found_o(found),
        .lock_lo_o(lo), .lock_hi_o(hi)
    );

    always #5 clk = ~clk;

    // Error stimulus by mode: 0 zero, 1 +50, 2 three zeros then 40,
    // 3 -128, 4 -8 (tolerance edge, in), 5 +9 (just out).
    always @(negedge clk) begin
        ph = ph + 1;
        case (mode)
            0: err = 8'sd0;
            1: err = 8'sd50;
            2: err = ((ph % 4) == 3) ? 8'sd40 : 8'sd0;
            3: err = 8'sh80;
            4: err = -8'sd8;
            5: err = 8'sd9;
            default: err = 8'sd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    typedef struct {
        logic [AW-1:0] ks, kp, kt;
        int            md;
        int            cyc;
        int            nk;
        logic [AW-1:0] last_k;
        logic          fnd;
        logic [AW-1:0] elo, ehi;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int i);
        int n;
        int nk;
        logic [AW-1:0] last;
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        mode = v.md; k_start = v.ks; k_stop = v.kp; k_step = v.kt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; nk = 1; last = k_val;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (k_val !== last) begin
                nk++;
                last = k_val;
            end
        end
        chk($sformatf("v%0d cycles", i), n, v.cyc);
        chk($sformatf("v%0d num_k", i), nk, v.nk);
        chk($sformatf("v%0d last_k", i), last, v.last_k);
        chk($sformatf("v%0d done", i), done, 1);
        chk($sformatf("v%0d busy", i), busy, 0);
        chk($sformatf("v%0d found", i), found, v.fnd);
        chk($sformatf("v%0d lock_lo", i), lo, v.elo);
        chk($sformatf("v%0d lock_hi", i), hi, v.ehi);
    endtask

    initial begin
        //          ks    kp    kt  md cyc nk last fnd lo    hi
        vecs[0] = '{12'd10,   12'd20,   12'd5, 0, 27, 3, 12'd20,   1'b1, 12'd10,   12'd20};
        vecs[1] = '{12'd10,   12'd20,   12'd5, 1, 63, 3, 12'd20,   1'b0, 12'd0,    12'd0};
        vecs[2] = '{12'd10,   12'd20,   12'd5, 2, 63, 3, 12'd20,   1'b0, 12'd0,    12'd0};
        vecs[3] = '{12'd10,   12'd20,   12'd5, 3, 63, 3, 12'd20,   1'b0, 12'd0,    12'd0};
        vecs[4] = '{12'd4090, 12'd4095, 12'd4, 0, 18, 2, 12'd4094, 1'b1, 12'd4090, 12'd4094};
        vecs[5] = '{12'd100,  12'd102,  12'd0, 0, 27, 3, 12'd102,  1'b1, 12'd100,  12'd102};
        vecs[6] = '{12'd20,   12'd10,   12'd5, 0, 0,  1, 12'd20,   1'b0, 12'd0,    12'd0};
        vecs[7] = '{12'd10,   12'd20,   12'd5, 4, 27, 3, 12'd20,   1'b1, 12'd10,   12'd20};
        vecs[8] = '{12'd10,   12'd20,   12'd5, 5, 63, 3, 12'd20,   1'b0, 12'd0,    12'd0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst k_val", k_val, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst found", found, 0);
        chk("rst lock_lo", lo, 0);
        chk("rst lock_hi", hi, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_vec(i);

        // Start ignored while busy, then abort (with start) during MEASURE of k=15.
        @(negedge clk);
        mode = 0; k_start = 12'd10; k_stop = 12'd20; k_step = 12'd5; start = 1'b1;
        @(negedge clk);                         // N0: SETTLE, k=10
        start = 1'b0;
        repeat (2) @(negedge clk);              // N2
        k_start = 12'd0; start = 1'b1;
        @(negedge clk);                         // N3
        start = 1'b0; k_start = 12'd10;
        chk("busy start ignored k_val", k_val, 10);
        chk("busy start ignored busy", busy, 1);
        repeat (11) @(negedge clk);             // N14: MEASURE at k=15
        chk("pre-abort k_val", k_val, 15);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);                         // N15
        abort = 1'b0; start = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort k_val", k_val, 15);
        chk("abort found", found, 1);
        chk("abort lock_lo", lo, 10);
        chk("abort lock_hi", hi, 10);
        repeat (3) @(negedge clk);
        chk("abort stays idle", busy, 0);

        // Asynchronous reset mid-SETTLE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-reset busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst k_val", k_val, 0);
        chk("async rst busy", busy, 0);
        chk("async rst found", found, 0);
        chk("async rst lock_lo", lo, 0);
        chk("async rst lock_hi", hi, 0);
        chk("async rst done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post-reset idle busy", busy, 0);
        chk("post-reset idle k_val", k_val, 0);

        // Fresh sweep from IDLE after reset
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
